// File: rtl/reg_array_pkg.sv
// reg_array_pkg
// Shared types and helpers for reg_array_bank.
//   state_t     : clear-sequencer state (ST_CLEAR sweeps zeros, ST_IDLE serves accesses)
//   LANE_MAX_W  : widest data word lane_merge can handle
//   lane_merge  : byte-lane masked merge of a new word into an old word
package reg_array_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // lane_merge works on a fixed maximum width so one package function serves
  // every WIDTH; callers zero-extend in and truncate out.
  localparam int LANE_MAX_W = 256;

  function automatic logic [LANE_MAX_W-1:0] lane_merge(
    input logic [LANE_MAX_W-1:0]   old_v,
    input logic [LANE_MAX_W-1:0]   new_v,
    input logic [LANE_MAX_W/8-1:0] be_v
  );
    logic [LANE_MAX_W-1:0] res;
    res = old_v;
    for (int i = 0; i < LANE_MAX_W / 8; i++) begin
      if (be_v[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_array_bank.sv
// reg_array_bank
// Single-port register array with byte-lane writes, a registered read port
// and a clear sequencer that zeroes every entry after reset and on clr.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   sel       : access request, sampled each rising edge
//   wr        : 1 = write, 0 = read (with sel)
//   addr      : entry index (may exceed DEPTH-1 when DEPTH is not a power of two)
//   wdata     : write data
//   be        : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   clr       : start a full clear sweep (ignored while one is running)
//   rdata     : registered read data, holds until the next read
//   rvalid    : one-cycle pulse qualifying rdata
//   busy      : high while the clear sweep runs
//   err       : one-cycle pulse for a rejected or out-of-range access
//   dbg_state : current sequencer state, for observation only
//
// Handshake: there is no backpressure. A request is taken on every edge where
// sel=1; its response (rvalid and/or err) appears for exactly one cycle after
// that edge, and a request that produces neither pulse completed silently.
//
// WIDTH must be a multiple of 8 and no larger than LANE_MAX_W.
module reg_array_bank
  import reg_array_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 wr,
  input  logic [AW-1:0]        addr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   be,
  input  logic                 clr,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 busy,
  output logic                 err,
  output state_t               dbg_state
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  // Plain array with no reset term; the sweep is what zeroes it.
  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             in_range;
  logic [WIDTH-1:0] merged;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  // Only consumed when in_range, so the out-of-range index never matters.
  assign merged = WIDTH'(lane_merge(LANE_MAX_W'(mem[addr]),
                                    LANE_MAX_W'(wdata),
                                    (LANE_MAX_W / 8)'(be)));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
        // Accesses cannot be served mid-sweep; clr here is simply ignored.
        err_d = sel;
      end

      default: begin
        if (clr) begin
          // clr wins over a same-cycle access, which is then reported as dropped.
          state_d = ST_CLEAR;
          ptr_d   = '0;
          err_d   = sel;
        end else if (sel) begin
          if (!in_range) begin
            err_d = 1'b1;
            if (!wr) begin
              rdata_d  = '0;
              rvalid_d = 1'b1;
            end
          end else if (wr) begin
            // be=0 still takes this path and rewrites the old word unchanged.
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = merged;
          end else begin
            rdata_d  = mem[addr];
            rvalid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign busy      = (state_q == ST_CLEAR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_array_bank.sv
// tb_reg_array_bank
// Drives a DEPTH=4 and a DEPTH=3 instance (both WIDTH=16) from shared clk/rst.
// A behavioural model tracks each array's contents, sweep length and last read
// value; expected responses are queued and checked by a negedge monitor.
module tb_reg_array_bank;
  import reg_array_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel   [2];
  logic        wr    [2];
  logic [1:0]  addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  be    [2];
  logic        clr   [2];
  logic [15:0] rdata [2];
  logic        rvalid[2];
  logic        busy  [2];
  logic        err   [2];
  state_t      dbg   [2];

  reg_array_bank #(.WIDTH(16), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .sel(sel[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .clr(clr[0]), .rdata(rdata[0]),
    .rvalid(rvalid[0]), .busy(busy[0]), .err(err[0]), .dbg_state(dbg[0])
  );

  reg_array_bank #(.WIDTH(16), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .sel(sel[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .clr(clr[1]), .rdata(rdata[1]),
    .rvalid(rvalid[1]), .busy(busy[1]), .err(err[1]), .dbg_state(dbg[1])
  );

  // Reference model state
  int          dep [2] = '{4, 3};
  int          left[2];          // sweep edges still to go; busy while > 0
  logic [15:0] mmem[2][4];
  logic [15:0] last_rd[2];

  // Expected response: {cycle[15:0], rvalid, err, rdata[15:0]}
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit started = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      sel[k] = 1'b0; wr[k] = 1'b0; addr[k] = 2'd0;
      wdata[k] = 16'h0; be[k] = 2'b00; clr[k] = 1'b0;
    end
  endtask

  task automatic set_acc(input int k, input logic w, input logic [1:0] a,
                         input logic [15:0] d, input logic [1:0] b);
    sel[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
  endtask

  task automatic push_exp(input int k, input logic rv, input logic er,
                          input logic [15:0] rd);
    logic [33:0] e;
    e = {cyc[15:0], rv, er, rd};
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic zero_model(input int k);
    for (int i = 0; i < 4; i++) mmem[k][i] = 16'h0;
  endtask

  // Applies the block's rules to one edge, using the inputs it sampled.
  task automatic model_step(input int k);
    if (!rst) begin
      left[k]    = dep[k];
      last_rd[k] = 16'h0;
      zero_model(k);
    end else if (left[k] > 0) begin
      if (sel[k]) push_exp(k, 1'b0, 1'b1, last_rd[k]);
      left[k] = left[k] - 1;
    end else if (clr[k]) begin
      if (sel[k]) push_exp(k, 1'b0, 1'b1, last_rd[k]);
      left[k] = dep[k];
      zero_model(k);
    end else if (sel[k]) begin
      if (int'(addr[k]) >= dep[k]) begin
        if (!wr[k]) begin
          last_rd[k] = 16'h0;
          push_exp(k, 1'b1, 1'b1, 16'h0);
        end else begin
          push_exp(k, 1'b0, 1'b1, last_rd[k]);
        end
      end else if (wr[k]) begin
        for (int b = 0; b < 2; b++)
          if (be[k][b]) mmem[k][addr[k]][8*b +: 8] = wdata[k][8*b +: 8];
      end else begin
        last_rd[k] = mmem[k][addr[k]];
        push_exp(k, 1'b1, 1'b0, last_rd[k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    model_step(0);
    model_step(1);
    #1;
    idle_all();
  endtask

  task automatic do_wr(input int k, input logic [1:0] a, input logic [15:0] d,
                       input logic [1:0] b);
    set_acc(k, 1'b1, a, d, b);
    tick();
  endtask

  task automatic do_rd(input int k, input logic [1:0] a);
    set_acc(k, 1'b0, a, 16'h0, 2'b00);
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int k);
    logic [33:0] e;
    bit          have;
    logic        exp_busy;
    exp_busy = (left[k] > 0);

    n_tests++;
    if (busy[k] !== exp_busy) begin
      n_fail++;
      $display("FAIL busy[%0d] cyc %0d: got %b want %b", k, cyc, busy[k], exp_busy);
    end

    n_tests++;
    if ((dbg[k] == ST_CLEAR) !== exp_busy) begin
      n_fail++;
      $display("FAIL state[%0d] cyc %0d: got %b want clear=%b", k, cyc, dbg[k], exp_busy);
    end

    n_tests++;
    if (rdata[k] !== last_rd[k]) begin
      n_fail++;
      $display("FAIL rdata_hold[%0d] cyc %0d: got %h want %h", k, cyc, rdata[k], last_rd[k]);
    end

    have = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    if (rvalid[k] !== 1'b0 || err[k] !== 1'b0) begin
      n_tests++;
      if (!have) begin
        n_fail++;
        $display("FAIL unexpected[%0d] cyc %0d: got rvalid=%b err=%b rdata=%h want no response",
                 k, cyc, rvalid[k], err[k], rdata[k]);
      end else begin
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        if ({cyc[15:0], rvalid[k], err[k], rdata[k]} !== e) begin
          n_fail++;
          $display("FAIL resp[%0d] cyc %0d: got rvalid=%b err=%b rdata=%h want cyc %0d rvalid=%b err=%b rdata=%h",
                   k, cyc, rvalid[k], err[k], rdata[k], e[33:18], e[17], e[16], e[15:0]);
        end
      end
    end else if (have) begin
      e = (k == 0) ? exp_q0[0] : exp_q1[0];
      if (e[33:18] == cyc[15:0]) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing[%0d] cyc %0d: got no response want rvalid=%b err=%b rdata=%h",
                 k, cyc, e[17], e[16], e[15:0]);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    rst = 1'b0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b1;
    repeat (5) tick();                          // sweep, then one idle cycle

    // Fresh contents read back as zero
    for (int a = 0; a < 4; a++) begin
      set_acc(0, 1'b0, 2'(a), 16'h0, 2'b00);
      if (a < 3) set_acc(1, 1'b0, 2'(a), 16'h0, 2'b00);
      tick();
    end

    // Write/readback and byte lanes
    do_wr(0, 2'd1, 16'hABCD, 2'b11);
    do_rd(0, 2'd1);
    do_rd(0, 2'd2);
    do_wr(0, 2'd1, 16'h1234, 2'b01);
    do_rd(0, 2'd1);
    do_wr(0, 2'd1, 16'h5555, 2'b00);
    do_rd(0, 2'd1);

    // Out of range on the DEPTH=3 instance
    for (int a = 0; a < 3; a++) do_wr(1, 2'(a), 16'(16'h1111 * (a + 1)), 2'b11);
    do_rd(1, 2'd3);
    do_wr(1, 2'd3, 16'hFFFF, 2'b11);
    for (int a = 0; a < 3; a++) do_rd(1, 2'(a));

    // clr with a colliding write, then a read while busy
    for (int a = 0; a < 4; a++) do_wr(0, 2'(a), 16'($urandom), 2'b11);
    set_acc(0, 1'b1, 2'd0, 16'hFFFF, 2'b11);
    clr[0] = 1'b1;
    tick();
    do_rd(0, 2'd2);
    clr[0] = 1'b1;                              // ignored mid-sweep
    repeat (4) tick();
    for (int a = 0; a < 4; a++) do_rd(0, 2'(a));

    // Reset in the middle of a sweep (ptr=2)
    do_wr(0, 2'd3, 16'hBEEF, 2'b11);
    clr[0] = 1'b1;
    tick();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    do_rd(0, 2'd3);

    // clr held through the end of a sweep restarts at the first idle edge
    repeat (7) begin
      clr[0] = 1'b1;
      tick();
    end
    repeat (5) tick();

    // Randomised traffic on both instances
    repeat (600) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 99) < 70)
          set_acc(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  16'($urandom), 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 99) < 4) clr[k] = 1'b1;
      end
      rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    repeat (6) tick();

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d responses outstanding want 0/0",
               exp_q0.size(), exp_q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
